// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: checks the RED->GREEN->YELLOW sequence and per-phase dwell, drives one-hot lamps
// and latches a fault code with flashing red until cleared.
module traffic_light_monitor #(
  parameter int TICK_W = 4,
  parameter int MIN_RED_TICKS = 4,
  parameter int MIN_GREEN_TICKS = 4,
  parameter int MIN_YELLOW_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] light_code,
  input  logic       clear_fault,
  output logic       lamp_red,
  output logic       lamp_yellow,
  output logic       lamp_green,
  output logic       fault,
  output logic [1:0] fault_code
);
  // phase states share their encoding with the light code they accept
  typedef enum logic [2:0] {RED = 3'd0, GREEN = 3'd1, YELLOW = 3'd2, FAULT = 3'd3, INIT = 3'd4} state_t;
  localparam logic [TICK_W-1:0] SAT = {TICK_W{1'b1}};
  if (MIN_RED_TICKS > 2**TICK_W-1 || MIN_GREEN_TICKS > 2**TICK_W-1 || MIN_YELLOW_TICKS > 2**TICK_W-1) begin : g_chk
    $error("MIN_*_TICKS exceeds dwell counter range");
  end
  state_t state, state_n;
  logic [1:0] code_q, fc_n, succ;
  logic [TICK_W-1:0] dwell, dwell_n, min_t;
  logic flash, flash_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= INIT;
      code_q <= '0;
      dwell <= '0;
      flash <= 1'b0;
      fault_code <= '0;
    end else begin
      state <= state_n;
      code_q <= light_code;
      dwell <= dwell_n;
      flash <= flash_n;
      fault_code <= fc_n;
    end
  always_comb begin
    succ = (state == YELLOW) ? 2'b00 : state[1:0] + 2'b01;
    min_t = (state == RED) ? TICK_W'(MIN_RED_TICKS) : (state == GREEN) ? TICK_W'(MIN_GREEN_TICKS) : TICK_W'(MIN_YELLOW_TICKS);
    state_n = state;
    dwell_n = dwell;
    flash_n = flash;
    fc_n = fault_code;
    case (state)
      INIT:
        if (code_q == 2'b00) state_n = RED;
        else if (code_q == 2'b11) begin
          state_n = FAULT;
          fc_n = 2'b11;
        end
      FAULT:
        if (clear_fault && code_q == 2'b00) begin
          state_n = RED;
          dwell_n = '0;
          flash_n = 1'b0;
          fc_n = 2'b00;
        end else if (tick) flash_n = !flash;
      default:
        if (code_q == state[1:0]) dwell_n = (tick && dwell != SAT) ? dwell + 1'b1 : dwell;
        else if (code_q == succ && dwell >= min_t) begin
          state_n = state_t'({1'b0, succ});
          dwell_n = '0;
        end else begin
          state_n = FAULT;
          dwell_n = '0;
          flash_n = 1'b0;
          fc_n = (code_q == 2'b11) ? 2'b11 : (code_q == succ) ? 2'b10 : 2'b01;
        end
    endcase
  end
  always_comb begin
    lamp_red = (state == INIT) || (state == RED) || (state == FAULT && flash);
    lamp_yellow = state == YELLOW;
    lamp_green = state == GREEN;
    fault = state == FAULT;
  end
endmodule
